// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: clear-sequencer
// state encoding and helpers for slicing the flattened read-port buses.
package regfile_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // LSB position of port k inside a flattened bus of w-bit lanes
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file bus: one write port, NREAD flattened read ports, clear/busy.
interface regfile_mp_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 3,
  parameter int NREAD  = 2
);
  logic                      clr;
  logic                      busy;
  logic                      we;
  logic [AWIDTH-1:0]         wsel;
  logic [DWIDTH-1:0]         wdata;
  logic [NREAD*AWIDTH-1:0]   rsel;
  logic [NREAD*DWIDTH-1:0]   rdata;

  modport master (output clr, we, wsel, wdata, rsel, input busy, rdata);
  modport slave  (input clr, we, wsel, wdata, rsel, output busy, rdata);
endinterface

// File: rtl/regfile_mp_clrseq.sv
// Clear sequencer: walks idx over every entry after reset or a clr request.
//
// state    | meaning
// ST_CLEAR | writing CLRVAL to entry idx, busy high
// ST_IDLE  | clear done, user writes accepted
module regfile_mp_clrseq
  import regfile_pkg::*;
#(
  parameter int AWIDTH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [AWIDTH-1:0] clr_addr
);

  localparam logic [AWIDTH-1:0] IDX_LAST = '1;

  clr_state_t        state, state_nxt;
  logic [AWIDTH-1:0] idx, idx_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: begin
        if (clr) begin
          state_nxt = ST_CLEAR;
          idx_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        // a clr during the walk restarts it, so the walk always ends DEPTH cycles after the last request
        if (clr) begin
          idx_nxt = '0;
        end else begin
          idx_nxt = idx + AWIDTH'(1);
          if (idx == IDX_LAST) state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        idx_nxt   = '0;
      end
    endcase
  end

  assign busy     = (state == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = idx;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational reads, one synchronous write,
// built-in clear walk. REGFILE_MP_BYPASS_EN enables same-cycle write-through.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int                 DWIDTH  = 16,
  parameter int                 AWIDTH  = 3,
  parameter int                 NREAD   = 2,
  parameter logic [DWIDTH-1:0]  CLRVAL  = '0,
  parameter bit                 ZERO_R0 = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic              busy;
  logic              clr_we;
  logic [AWIDTH-1:0] clr_addr;

  regfile_mp_clrseq #(.AWIDTH(AWIDTH)) u_clrseq (
    .clk      (clk),
    .reset    (reset),
    .clr      (bus.clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign bus.busy = busy;

  // the clear walk owns the array while busy, so user writes are simply dropped
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= CLRVAL;
    end else if (bus.we && !(ZERO_R0 && bus.wsel == '0)) begin
      mem[bus.wsel] <= bus.wdata;
    end
  end

  logic [AWIDTH-1:0]       ra;
  logic [DWIDTH-1:0]       rd;
  logic [NREAD*DWIDTH-1:0] rdata_flat;

  always_comb begin
    rdata_flat = '0;
    ra         = '0;
    rd         = '0;
    for (int k = 0; k < NREAD; k++) begin
      ra = bus.rsel[slice_lo(k, AWIDTH) +: AWIDTH];
      rd = mem[ra];
`ifdef REGFILE_MP_BYPASS_EN
      if (bus.we && ra == bus.wsel) rd = bus.wdata;
`endif
      if (busy || (ZERO_R0 && ra == '0)) rd = '0;
      rdata_flat[slice_lo(k, DWIDTH) +: DWIDTH] = rd;
    end
  end

  assign bus.rdata = rdata_flat;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: two instances (plain and ZERO_R0=1)
// driven identically and compared against a simple array/countdown model.
module tb_regfile_mp;

  localparam int              DW  = 16;
  localparam int              AW  = 3;
  localparam int              NR  = 3;
  localparam int              DEP = 8;
  localparam logic [DW-1:0]   CV  = 16'hA5A5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0;
  logic we = 1'b0;
  logic [AW-1:0]    wsel = '0;
  logic [DW-1:0]    wdata = '0;
  logic [NR*AW-1:0] rsel = '0;

  always #5 clk = ~clk;

  regfile_mp_if #(.DWIDTH(DW), .AWIDTH(AW), .NREAD(NR)) bus_n ();
  regfile_mp_if #(.DWIDTH(DW), .AWIDTH(AW), .NREAD(NR)) bus_z ();

  assign bus_n.clr = clr;   assign bus_z.clr = clr;
  assign bus_n.we = we;     assign bus_z.we = we;
  assign bus_n.wsel = wsel; assign bus_z.wsel = wsel;
  assign bus_n.wdata = wdata; assign bus_z.wdata = wdata;
  assign bus_n.rsel = rsel; assign bus_z.rsel = rsel;

  regfile_mp #(.DWIDTH(DW), .AWIDTH(AW), .NREAD(NR), .CLRVAL(CV), .ZERO_R0(1'b0))
    dut_n (.clk(clk), .reset(reset), .bus(bus_n));
  regfile_mp #(.DWIDTH(DW), .AWIDTH(AW), .NREAD(NR), .CLRVAL(CV), .ZERO_R0(1'b1))
    dut_z (.clk(clk), .reset(reset), .bus(bus_z));

  int checks = 0;
  int failures = 0;

  // model: per-instance contents plus number of clear cycles still to run
  logic [DW-1:0] m_mem [2][DEP];
  int            clear_left = DEP;

  function automatic logic [DW-1:0] exp_rd(input int z, input logic [AW-1:0] a);
    if (reset || clear_left > 0) return '0;
    if (z == 1 && a == 0) return '0;
`ifdef REGFILE_MP_BYPASS_EN
    if (we && a == wsel) return wdata;
`endif
    return m_mem[z][a];
  endfunction

  task automatic model_step();
    if (reset) begin
      clear_left = DEP;
    end else if (clear_left > 0) begin
      if (clr) clear_left = DEP;
      else begin
        clear_left--;
        if (clear_left == 0)
          for (int z = 0; z < 2; z++)
            for (int i = 0; i < DEP; i++) m_mem[z][i] = CV;
      end
    end else begin
      if (we) begin
        m_mem[0][wsel] = wdata;
        if (wsel != 0) m_mem[1][wsel] = wdata;
      end
      if (clr) clear_left = DEP;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] port_n(input int k);
    return bus_n.rdata[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] port_z(input int k);
    return bus_z.rdata[k*DW +: DW];
  endfunction

  task automatic check_all(input string ph);
    logic [AW-1:0] a;
    logic          eb;
    eb = reset || (clear_left > 0);
    chk({ph, "/busy_n"}, {15'b0, bus_n.busy}, {15'b0, eb});
    chk({ph, "/busy_z"}, {15'b0, bus_z.busy}, {15'b0, eb});
    for (int k = 0; k < NR; k++) begin
      a = rsel[k*AW +: AW];
      chk($sformatf("%s/rd_n%0d@%0d", ph, k, a), port_n(k), exp_rd(0, a));
      chk($sformatf("%s/rd_z%0d@%0d", ph, k, a), port_z(k), exp_rd(1, a));
    end
  endtask

  task automatic set_rsel(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rsel = {a2, a1, a0};
  endtask

  int n;

  initial begin
    // reset: busy and zero reads while held
    #2 reset = 1'b1;
    #1;
    chk("reset_busy", {15'b0, bus_n.busy}, 16'd1);
    check_all("reset");
    tick();
    tick();
    check_all("reset_hold");
    reset = 1'b0;
    #1;
    for (int i = 0; i < DEP; i++) begin
      chk($sformatf("clr_busy%0d", i), {15'b0, bus_n.busy}, 16'd1);
      chk($sformatf("clr_rd0_%0d", i), port_n(0), 16'h0000);
      check_all("post_reset");
      tick();
    end
    chk("clr_done_busy", {15'b0, bus_n.busy}, 16'd0);
    for (int a = 0; a < DEP; a++) begin
      set_rsel(AW'(a), AW'(a), AW'(a));
      #1;
      chk($sformatf("clrval_n%0d", a), port_n(NR-1), CV);
      chk($sformatf("clrval_z%0d", a), port_z(1), (a == 0) ? 16'h0000 : CV);
      check_all("clrval");
    end

    // writes and port independence
    set_rsel(3'd3, 3'd5, 3'd3);
    we = 1'b1; wsel = 3'd3; wdata = 16'h1234;
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("wr3_same_cycle", port_n(0), 16'h1234);
`else
    chk("wr3_same_cycle", port_n(0), CV);
`endif
    check_all("wr3");
    tick();
    wsel = 3'd5; wdata = 16'hBEEF;
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("wr5_same_cycle", port_n(1), 16'hBEEF);
`else
    chk("wr5_same_cycle", port_n(1), CV);
`endif
    check_all("wr5");
    tick();
    we = 1'b0;
    #1;
    chk("rd_p0", port_n(0), 16'h1234);
    chk("rd_p1", port_n(1), 16'hBEEF);
    chk("rd_p2", port_n(2), 16'h1234);
    check_all("rd3");

    // entry 0 hardwired on the ZERO_R0 instance
    we = 1'b1; wsel = 3'd0; wdata = 16'hFFFF;
    tick();
    wsel = 3'd1; wdata = 16'h0001;
    tick();
    we = 1'b0;
    set_rsel(3'd0, 3'd1, 3'd0);
    #1;
    chk("z_r0", port_z(0), 16'h0000);
    chk("z_r1", port_z(1), 16'h0001);
    chk("n_r0", port_n(0), 16'hFFFF);
    check_all("zero_r0");

    // write-through bypass
    set_rsel(3'd4, 3'd3, 3'd4);
    we = 1'b1; wsel = 3'd4; wdata = 16'h55AA;
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("byp_same", port_n(0), 16'h55AA);
`else
    chk("byp_same", port_n(0), CV);
`endif
    check_all("bypass");
    tick();
    we = 1'b0;
    #1;
    chk("byp_next", port_n(0), 16'h55AA);
    check_all("bypass_next");

    // write during clear is dropped
    clr = 1'b1;
    tick();
    clr = 1'b0;
    we = 1'b1; wsel = 3'd2; wdata = 16'h7777;
    set_rsel(3'd2, 3'd4, 3'd3);
    n = 0;
    while (bus_n.busy && n < 40) begin
      #1;
      check_all("drop");
      n++;
      tick();
    end
    chk("drop_busy_len", 16'(n), 16'd8);
    we = 1'b0;
    #1;
    chk("drop_r2", port_n(0), CV);
    chk("drop_r4", port_n(1), CV);
    check_all("drop_after");

    // clr restart 3 cycles into the walk
    clr = 1'b1;
    tick();
    n = 0;
    while (bus_n.busy && n < 40) begin
      clr = (n == 2);
      #1;
      check_all("restart");
      n++;
      tick();
    end
    clr = 1'b0;
    chk("restart_busy_len", 16'(n), 16'd11);

    // randomized traffic, including write+clr together and one async reset
    for (int i = 0; i < 400; i++) begin
      we    = 1'($urandom_range(0, 1));
      wsel  = AW'($urandom_range(0, DEP-1));
      wdata = DW'($urandom);
      clr   = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) set_rsel(wsel, wsel, AW'($urandom_range(0, DEP-1)));
      else rsel = (NR*AW)'($urandom);
      if (i == 200) reset = 1'b1;
      if (i == 202) reset = 1'b0;
      #1;
      check_all("rand");
      tick();
    end
    clr = 1'b0; we = 1'b0;
    #1;
    check_all("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file: NREAD combinational read ports and one synchronous write port.
- Built-in clear sequencer walks every entry to CLRVAL after reset or on request; busy is high while clearing.
- Optional hardwired-zero entry 0.
- Sits in the CPU datapath as the general register bank, replacing the fixed 2-read-port file.

Parameters:
DWIDTH, 16, data width in bits (>=1)
AWIDTH, 3, address width; DEPTH = 2**AWIDTH entries (>=1)
NREAD, 2, number of read ports (>=1)
CLRVAL, 0, value written to every entry by the clear sequence (DWIDTH bits)
ZERO_R0, 0, 1 = entry 0 always reads 0 and ignores writes

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high; starts clear sequence
clr  input  1  synchronous clear request; restarts clear sequence from entry 0
busy  output  1  high while clear sequence is running
we  input  1  write enable
wsel  input  AWIDTH  write address
wdata  input  DWIDTH  write data
rsel  input  NREAD*AWIDTH  read addresses; port k uses bits [k*AWIDTH +: AWIDTH]
rdata  output  NREAD*DWIDTH  read data; port k on bits [k*DWIDTH +: DWIDTH]

Behaviour:
- One clock (clk); reset is asynchronous and active-high (reset).
- States (clear sequencer): CLEAR, IDLE. Index counter idx is AWIDTH bits.
- reset asserted: state=CLEAR, idx=0, busy=1 immediately, asynchronously. Storage array is not reset directly.
- CLEAR: on each posedge, R[idx]<=CLRVAL and idx<=idx+1.
  - If idx==DEPTH-1, go to IDLE and busy<=0.
  - busy is therefore high for exactly DEPTH clocks after reset deasserts.
- IDLE: if clr is sampled high, go to CLEAR with idx=0 and busy=1 from the next cycle; otherwise stay.
- clr while in CLEAR: restarts at idx=0. The sequence is then DEPTH cycles from the last clr.
- Writes:
  - In IDLE with we=1, R[wsel]<=wdata at posedge; visible on reads the cycle after.
  - we while busy=1 is dropped; no queueing.
  - we and clr in the same IDLE cycle: the write happens and the clear starts next cycle. Net result: all entries end at CLRVAL.
- Reads:
  - Combinational: rdata[k] = R[rsel[k]].
  - While busy=1, every rdata port is forced to 0. In reset, rdata=0 and busy=1.
  - Reads of the same address on multiple ports return identical data.
- ZERO_R0=1: reads of address 0 return 0 always. Writes to 0 are ignored. The clear sequence still counts through entry 0, so busy timing is unchanged.
- idx wraps naturally at DEPTH; no out-of-range addresses exist.
- Reset mid-clear or mid-write: the sequence restarts, and any in-flight write is lost.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN
- Defined: when busy=0, we=1 and rsel[k]==wsel (and not the ZERO_R0 address-0 case), rdata[k]=wdata in the same cycle (write-through bypass).
- Undefined: rdata[k] shows the old value until the cycle after the write.
- Has no effect while busy=1.

Decomposition:
- Shared package regfile_pkg:
  - clear-sequencer state encodings (ST_IDLE=1'b0, ST_CLEAR=1'b1)
  - port-slice helper macros/functions for flattened rsel/rdata
- Sub-module regfile_mp_clrseq: owns state, idx and busy; outputs clr_we/clr_addr to the array.
- Top level: storage, write mux (clear vs. user), read ports, bypass.

Test Plan:
- Reset sequence: DWIDTH=16, AWIDTH=3, CLRVAL=16'hA5A5. Assert reset, release -> busy high for exactly 8 clocks and rdata=0 throughout. Then every rsel reads 16'hA5A5.
- Writes and port independence: NREAD=3. Write R3=16'h1234, R5=16'hBEEF. Set rsel={3,5,3} -> rdata={1234,BEEF,1234} the cycle after the writes. Neither value is visible during its write cycle (bypass off).
- Write dropped while busy: pulse clr, then we=1, wsel=2, wdata=16'h7777 during busy -> after busy falls, R2 reads CLRVAL.
- clr restart: pulse clr, then pulse it again 3 cycles into the sequence -> busy lasts 3+8=11 cycles total.
- ZERO_R0=1: write R0=16'hFFFF -> R0 reads 0. Write R1=16'h0001 -> reads 0001.
- Bypass: with REGFILE_MP_BYPASS_EN, we=1, wsel=4, wdata=16'h55AA, rsel[0]=4 -> rdata[0]=55AA in the same cycle. Without the macro it reads the old value in that cycle and 55AA in the next.
